// File: rtl/pattern_gen_pkg.sv
// Shared types and helpers for the pattern generator: mode encoding,
// default Galois LFSR tap masks per channel width, and binary-to-Gray.
package pattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_WALK  = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_GRAY  = 2'd3
    } mode_e;

    // Builds a right-shifting Galois tap mask from up to four tap numbers
    // (tap n sets bit n-1; a tap of 0 means unused).
    function automatic logic [63:0] tap_mask(input int a, input int b, input int c, input int d);
        logic [63:0] m;
        m = '0;
        if (a > 0) m = m | (64'd1 << (a - 1));
        if (b > 0) m = m | (64'd1 << (b - 1));
        if (c > 0) m = m | (64'd1 << (c - 1));
        if (d > 0) m = m | (64'd1 << (d - 1));
        return m;
    endfunction

    // Maximal-length tap mask for each legal channel width.
    function automatic logic [63:0] default_poly(input int width);
        logic [63:0] p;
        case (width)
            2:  p = tap_mask(2, 1, 0, 0);
            3:  p = tap_mask(3, 2, 0, 0);
            4:  p = tap_mask(4, 3, 0, 0);
            5:  p = tap_mask(5, 3, 0, 0);
            6:  p = tap_mask(6, 5, 0, 0);
            7:  p = tap_mask(7, 6, 0, 0);
            8:  p = 64'hB8;
            9:  p = tap_mask(9, 5, 0, 0);
            10: p = tap_mask(10, 7, 0, 0);
            11: p = tap_mask(11, 9, 0, 0);
            12: p = tap_mask(12, 6, 4, 1);
            13: p = tap_mask(13, 4, 3, 1);
            14: p = tap_mask(14, 5, 3, 1);
            15: p = tap_mask(15, 14, 0, 0);
            16: p = 64'hB400;
            17: p = tap_mask(17, 14, 0, 0);
            18: p = tap_mask(18, 11, 0, 0);
            19: p = tap_mask(19, 6, 2, 1);
            20: p = tap_mask(20, 17, 0, 0);
            21: p = tap_mask(21, 19, 0, 0);
            22: p = tap_mask(22, 21, 0, 0);
            23: p = tap_mask(23, 18, 0, 0);
            24: p = tap_mask(24, 23, 22, 17);
            25: p = tap_mask(25, 22, 0, 0);
            26: p = tap_mask(26, 6, 2, 1);
            27: p = tap_mask(27, 5, 2, 1);
            28: p = tap_mask(28, 25, 0, 0);
            29: p = tap_mask(29, 27, 0, 0);
            30: p = tap_mask(30, 6, 4, 1);
            31: p = tap_mask(31, 28, 0, 0);
            32: p = 64'h80200003;
            33: p = tap_mask(33, 20, 0, 0);
            34: p = tap_mask(34, 27, 2, 1);
            35: p = tap_mask(35, 33, 0, 0);
            36: p = tap_mask(36, 25, 0, 0);
            37: p = tap_mask(37, 5, 4, 3) | tap_mask(2, 1, 0, 0);
            38: p = tap_mask(38, 6, 5, 1);
            39: p = tap_mask(39, 35, 0, 0);
            40: p = tap_mask(40, 38, 21, 19);
            41: p = tap_mask(41, 38, 0, 0);
            42: p = tap_mask(42, 41, 20, 19);
            43: p = tap_mask(43, 42, 38, 37);
            44: p = tap_mask(44, 43, 18, 17);
            45: p = tap_mask(45, 44, 42, 41);
            46: p = tap_mask(46, 45, 26, 25);
            47: p = tap_mask(47, 42, 0, 0);
            48: p = tap_mask(48, 47, 21, 20);
            49: p = tap_mask(49, 40, 0, 0);
            50: p = tap_mask(50, 49, 24, 23);
            51: p = tap_mask(51, 50, 36, 35);
            52: p = tap_mask(52, 49, 0, 0);
            53: p = tap_mask(53, 52, 38, 37);
            54: p = tap_mask(54, 53, 18, 17);
            55: p = tap_mask(55, 31, 0, 0);
            56: p = tap_mask(56, 55, 35, 34);
            57: p = tap_mask(57, 50, 0, 0);
            58: p = tap_mask(58, 39, 0, 0);
            59: p = tap_mask(59, 58, 38, 37);
            60: p = tap_mask(60, 59, 0, 0);
            61: p = tap_mask(61, 60, 46, 45);
            62: p = tap_mask(62, 61, 6, 5);
            63: p = tap_mask(63, 62, 0, 0);
            64: p = 64'hD800000000000000;
            default: p = tap_mask(2, 1, 0, 0);
        endcase
        return p;
    endfunction

    // Reflected binary code of a value (zero-extended to 64 bits).
    function automatic logic [63:0] bin2gray(input logic [63:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/pattern_gen_presc.sv
// Prescaler: raises adv_o once every div_i+1 enabled cycles. The >= compare
// means lowering div_i below the running count fires on the next enabled cycle.
// clr_i restarts the count when a new seed is loaded.
module pattern_gen_presc #(
    parameter int DIV_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             adv_o
);

    logic [DIV_W-1:0] cnt;

    assign adv_o = en_i && (cnt >= div_i);

    // Count enabled cycles, restarting on an advance or a seed load.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            cnt <= '0;
        end else if (clr_i || adv_o) begin
            cnt <= '0;
        end else if (en_i) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_gen.sv
// Logic-analyser test pattern generator: counter, walking one, Galois LFSR
// or Gray counter on CHLS channels, advanced by a programmable prescaler.
module pattern_gen
    import pattern_gen_pkg::*;
#(
    parameter int               CHLS  = 32,
    parameter int               DIV_W = 16,
    parameter logic [CHLS-1:0]  POLY  = CHLS'(pattern_gen_pkg::default_poly(CHLS))
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             load_i,
    input  logic [CHLS-1:0]  seed_i,
    output logic [CHLS-1:0]  chls_o,
    output logic             tick_o,
    output logic             wrap_o
);

    localparam logic [CHLS-1:0] ONE = CHLS'(1);

    mode_e           mode;
    logic            adv;
    logic [CHLS-1:0] st;
    logic [CHLS-1:0] seed_q;
    logic [CHLS-1:0] st_next;
    logic            wrap_next;
    logic [CHLS-1:0] enc_next;
    logic [CHLS-1:0] enc_seed;

    assign mode = mode_e'(mode_i);

    pattern_gen_presc #(
        .DIV_W (DIV_W)
    ) u_presc (
        .clk_i  (clk_i),
        .rst_in (rst_in),
        .en_i   (en_i),
        .clr_i  (load_i),
        .div_i  (div_i),
        .adv_o  (adv)
    );

    // Next pattern state and wrap flag for the active mode; an all-zero state
    // in WALK/LFSR is rescued to 1 so those sequences cannot lock up.
    always_comb begin
        st_next   = st;
        wrap_next = 1'b0;
        case (mode)
            MODE_COUNT, MODE_GRAY: begin
                st_next   = st + 1'b1;
                wrap_next = &st;
            end
            MODE_WALK: begin
                if (st == '0) begin
                    st_next = ONE;
                end else begin
                    st_next   = {st[CHLS-2:0], st[CHLS-1]};
                    wrap_next = st[CHLS-1];
                end
            end
            MODE_LFSR: begin
                if (st == '0) begin
                    st_next = ONE;
                end else begin
                    st_next = (st >> 1) ^ (st[0] ? POLY : '0);
                end
                wrap_next = (st_next == seed_q);
            end
            default: begin
                st_next   = st;
                wrap_next = 1'b0;
            end
        endcase
    end

    // Channel encoding: Gray mode shows the reflected code, others the raw state.
    always_comb begin
        enc_next = st_next;
        enc_seed = seed_i;
        if (mode == MODE_GRAY) begin
            enc_next = CHLS'(bin2gray(64'(st_next)));
            enc_seed = CHLS'(bin2gray(64'(seed_i)));
        end
    end

    // Pattern state and registered outputs; a load wins over a same-cycle advance.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            st     <= '0;
            seed_q <= ONE;
            chls_o <= '0;
            tick_o <= 1'b0;
            wrap_o <= 1'b0;
        end else if (load_i) begin
            st     <= seed_i;
            seed_q <= (seed_i == '0) ? ONE : seed_i;
            chls_o <= enc_seed;
            tick_o <= 1'b0;
            wrap_o <= 1'b0;
        end else if (adv) begin
            st     <= st_next;
            chls_o <= enc_next;
            tick_o <= 1'b1;
            wrap_o <= wrap_next;
        end else begin
            tick_o <= 1'b0;
            wrap_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pattern_gen.sv
// Directed bench for pattern_gen: an 8-channel instance for count, walk, Gray,
// load/enable and reset behaviour, and a 16-channel instance for the full LFSR period.
module tb_pattern_gen;
    import pattern_gen_pkg::*;

    logic        clk;
    logic        rstN;

    logic        en8;
    logic [1:0]  mode8;
    logic [15:0] div8;
    logic        load8;
    logic [7:0]  seed8;
    logic [7:0]  chls8;
    logic        tick8;
    logic        wrap8;

    logic        en16;
    logic [1:0]  mode16;
    logic [15:0] div16;
    logic        load16;
    logic [15:0] seed16;
    logic [15:0] chls16;
    logic        tick16;
    logic        wrap16;

    int total = 0;
    int bad   = 0;

    pattern_gen #(.CHLS(8), .DIV_W(16)) u8 (
        .clk_i  (clk),
        .rst_in (rstN),
        .en_i   (en8),
        .mode_i (mode8),
        .div_i  (div8),
        .load_i (load8),
        .seed_i (seed8),
        .chls_o (chls8),
        .tick_o (tick8),
        .wrap_o (wrap8)
    );

    pattern_gen #(.CHLS(16), .DIV_W(16)) u16 (
        .clk_i  (clk),
        .rst_in (rstN),
        .en_i   (en16),
        .mode_i (mode16),
        .div_i  (div16),
        .load_i (load16),
        .seed_i (seed16),
        .chls_o (chls16),
        .tick_o (tick16),
        .wrap_o (wrap16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value with its expected value and counts the result.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drives the 8-channel instance inputs.
    task automatic applyStimulus(input logic en, input logic [1:0] mode, input logic [15:0] div,
                                 input logic load, input logic [7:0] seed);
        en8   = en;
        mode8 = mode;
        div8  = div;
        load8 = load;
        seed8 = seed;
    endtask

    // Advances one clock and settles just after the rising edge.
    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]  grayExp [4];
    logic [7:0]  prevGray;
    logic [7:0]  walkExp;
    int          missingTicks;
    int          zeroSeen;
    int          earlyReturn;
    int          wrapCount;
    int          wrapAt;
    logic [15:0] firstLfsr;

    initial begin
        grayExp = '{8'h01, 8'h03, 8'h02, 8'h06};

        rstN   = 1'b0;
        applyStimulus(1'b1, 2'd0, 16'd0, 1'b0, 8'h00);
        en16   = 1'b0;
        mode16 = 2'd0;
        div16  = 16'd0;
        load16 = 1'b0;
        seed16 = 16'h0000;

        // Reset state
        repeat (2) stepCycle();
        checkOutput("rst_chls", 64'(chls8), 64'h0);
        checkOutput("rst_tick", 64'(tick8), 64'h0);
        checkOutput("rst_wrap", 64'(wrap8), 64'h0);

        // COUNT, div 0: advances every cycle straight out of reset
        $display("[TB] count mode");
        rstN = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            stepCycle();
            checkOutput("cnt_val", 64'(chls8), 64'(i));
            checkOutput("cnt_tick", 64'(tick8), 64'h1);
            checkOutput("cnt_nowrap", 64'(wrap8), 64'h0);
        end
        stepCycle();
        checkOutput("cnt_wrap_val", 64'(chls8), 64'h00);
        checkOutput("cnt_wrap_tick", 64'(tick8), 64'h1);
        checkOutput("cnt_wrap", 64'(wrap8), 64'h1);

        // WALK from a zero seed, load coinciding with an advance
        $display("[TB] walk mode");
        applyStimulus(1'b1, 2'd1, 16'd0, 1'b1, 8'h00);
        stepCycle();
        checkOutput("walk_load_val", 64'(chls8), 64'h00);
        checkOutput("walk_load_tick", 64'(tick8), 64'h0);
        applyStimulus(1'b1, 2'd1, 16'd0, 1'b0, 8'h00);
        for (int k = 1; k <= 9; k++) begin
            stepCycle();
            walkExp = (k <= 8) ? 8'(1 << (k - 1)) : 8'h01;
            checkOutput("walk_val", 64'(chls8), 64'(walkExp));
            checkOutput("walk_wrap", 64'(wrap8), 64'(k == 9));
        end

        // GRAY with div 3: tick every 4th cycle, single-bit changes
        $display("[TB] gray mode");
        applyStimulus(1'b1, 2'd3, 16'd3, 1'b1, 8'h00);
        stepCycle();
        checkOutput("gray_load_val", 64'(chls8), 64'h00);
        applyStimulus(1'b1, 2'd3, 16'd3, 1'b0, 8'h00);
        prevGray = 8'h00;
        for (int e = 1; e <= 16; e++) begin
            stepCycle();
            checkOutput("gray_tick", 64'(tick8), 64'((e % 4) == 0));
            if ((e % 4) == 0) begin
                checkOutput("gray_val", 64'(chls8), 64'(grayExp[e / 4 - 1]));
                checkOutput("gray_onebit", 64'($countones(chls8 ^ prevGray)), 64'd1);
                prevGray = chls8;
            end
        end

        // Load beats a same-cycle advance; enable low freezes pattern and count
        $display("[TB] load priority and enable hold");
        applyStimulus(1'b1, 2'd0, 16'd0, 1'b1, 8'h55);
        stepCycle();
        checkOutput("ld_val", 64'(chls8), 64'h55);
        checkOutput("ld_tick", 64'(tick8), 64'h0);
        checkOutput("ld_wrap", 64'(wrap8), 64'h0);
        applyStimulus(1'b1, 2'd0, 16'd2, 1'b0, 8'h55);
        repeat (2) begin
            stepCycle();
            checkOutput("pre_hold_tick", 64'(tick8), 64'h0);
        end
        applyStimulus(1'b0, 2'd0, 16'd2, 1'b0, 8'h55);
        for (int h = 0; h < 10; h++) begin
            stepCycle();
            checkOutput("hold_val", 64'(chls8), 64'h55);
            checkOutput("hold_tick", 64'(tick8), 64'h0);
        end
        applyStimulus(1'b1, 2'd0, 16'd2, 1'b0, 8'h55);
        stepCycle();
        checkOutput("resume_val", 64'(chls8), 64'h56);
        checkOutput("resume_tick", 64'(tick8), 64'h1);

        // Reset mid-count (cnt=2 of div 5) drops the pending advance
        $display("[TB] reset mid-count");
        applyStimulus(1'b1, 2'd0, 16'd5, 1'b1, 8'h10);
        stepCycle();
        applyStimulus(1'b1, 2'd0, 16'd5, 1'b0, 8'h10);
        repeat (2) stepCycle();
        checkOutput("pre_rst_val", 64'(chls8), 64'h10);
        rstN = 1'b0;
        #1;
        checkOutput("async_rst_val", 64'(chls8), 64'h0);
        checkOutput("async_rst_tick", 64'(tick8), 64'h0);
        checkOutput("async_rst_wrap", 64'(wrap8), 64'h0);
        stepCycle();
        rstN = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            stepCycle();
            checkOutput("post_rst_tick", 64'(tick8), 64'(k == 6));
        end
        checkOutput("post_rst_val", 64'(chls8), 64'h01);

        // 16-bit LFSR full period from seed 1
        $display("[TB] lfsr period");
        applyStimulus(1'b0, 2'd0, 16'd0, 1'b0, 8'h00);
        mode16 = 2'd2;
        div16  = 16'd0;
        en16   = 1'b1;
        load16 = 1'b1;
        seed16 = 16'h0001;
        stepCycle();
        checkOutput("lfsr_load_val", 64'(chls16), 64'h0001);
        checkOutput("lfsr_load_tick", 64'(tick16), 64'h0);
        load16       = 1'b0;
        missingTicks = 0;
        zeroSeen     = 0;
        earlyReturn  = 0;
        wrapCount    = 0;
        wrapAt       = 0;
        firstLfsr    = 16'h0;
        for (int n = 1; n <= 65535; n++) begin
            stepCycle();
            if (n == 1) firstLfsr = chls16;
            if (!tick16) missingTicks++;
            if (chls16 == 16'h0000) zeroSeen++;
            if (n < 65535 && chls16 == 16'h0001) earlyReturn++;
            if (wrap16) begin
                wrapCount++;
                wrapAt = n;
            end
        end
        checkOutput("lfsr_first", 64'(firstLfsr), 64'hB400);
        checkOutput("lfsr_ticks", 64'(missingTicks), 64'd0);
        checkOutput("lfsr_zero", 64'(zeroSeen), 64'd0);
        checkOutput("lfsr_early", 64'(earlyReturn), 64'd0);
        checkOutput("lfsr_wraps", 64'(wrapCount), 64'd1);
        checkOutput("lfsr_wrap_at", 64'(wrapAt), 64'd65535);
        checkOutput("lfsr_end_val", 64'(chls16), 64'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
